// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, counter encoding and saturating-counter helper for the branch predictor.
package bpu_pkg;
  typedef logic [1:0] ctr_t;
  localparam ctr_t ST_STRONGLY_NOT_TAKEN = 2'b00;
  localparam ctr_t ST_WEAKLY_NOT_TAKEN = 2'b01;
  localparam ctr_t ST_WEAKLY_TAKEN = 2'b10;
  localparam ctr_t ST_STRONGLY_TAKEN = 2'b11;
  // Tag is held at full PC width so the struct stays independent of TAG_W; unused upper bits are zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    ctr_t        ctr;
    logic [31:0] target;
  } bpu_entry_t;
  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;
  function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
    return taken ? ((ctr == ST_STRONGLY_TAKEN) ? ctr : ctr + 2'd1)
                 : ((ctr == ST_STRONGLY_NOT_TAKEN) ? ctr : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/bpu_table.sv
// bpu_table: direct-mapped predictor storage with two async read ports, one sync write port and a valid-clear port.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = 6
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] lookup_idx,
  output bpu_entry_t         lookup_entry,
  input  logic [INDEX_W-1:0] check_idx,
  output bpu_entry_t         check_entry,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  bpu_entry_t         wr_entry,
  input  logic               clr_en,
  input  logic [INDEX_W-1:0] clr_idx
);
  bpu_entry_t mem [ENTRIES];
  assign lookup_entry = mem[lookup_idx];
  assign check_entry = mem[check_idx];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_entry;
    if (clr_en) mem[clr_idx].valid <= 1'b0;
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit counter branch predictor with init/flush sweep and saturating mispredict count.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_predicted,
  output logic        ready,
  output logic [31:0] mispredict_count
);
  localparam int INDEX_W = $clog2(ENTRIES);
  state_t state;
  logic [INDEX_W-1:0] sweep_idx;
  logic [INDEX_W-1:0] l_idx, u_idx;
  logic [31:0] l_tag, u_tag;
  bpu_entry_t l_entry, u_entry, wr_entry;
  logic l_hit, u_hit, accept, wr_en;
  assign l_idx = lookup_pc[INDEX_W+1:2];
  assign u_idx = update_pc[INDEX_W+1:2];
  assign l_tag = 32'(lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2]);
  assign u_tag = 32'(update_pc[INDEX_W+TAG_W+1:INDEX_W+2]);
  assign ready = (state == READY);
  assign l_hit = l_entry.valid && (l_entry.tag == l_tag);
  assign u_hit = u_entry.valid && (u_entry.tag == u_tag);
  assign predict_taken = ready && l_hit && l_entry.ctr[1];
  assign predict_target = predict_taken ? l_entry.target : lookup_pc + 32'd4;
  assign accept = ready && update_valid && !flush_i;
  assign wr_en = accept && (u_hit || update_taken);
  // A hit keeps its target on not-taken; a miss can only get here when taken, so it allocates weakly taken.
  assign wr_entry = '{valid: 1'b1, tag: u_tag,
                      ctr: u_hit ? ctr_next(u_entry.ctr, update_taken) : ST_WEAKLY_TAKEN,
                      target: (u_hit && !update_taken) ? u_entry.target : update_target};
  bpu_table #(.ENTRIES(ENTRIES), .INDEX_W(INDEX_W)) u_table (
    .clk         (clk),
    .lookup_idx  (l_idx),
    .lookup_entry(l_entry),
    .check_idx   (u_idx),
    .check_entry (u_entry),
    .wr_en       (wr_en),
    .wr_idx      (u_idx),
    .wr_entry    (wr_entry),
    .clr_en      (state == INIT),
    .clr_idx     (sweep_idx)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      sweep_idx <= '0;
    end else if (flush_i) begin
      state <= INIT;
      sweep_idx <= '0;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == INDEX_W'(ENTRIES - 1)) state <= READY;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mispredict_count <= '0;
    else if (accept && (update_predicted != update_taken) && (mispredict_count != '1))
      mispredict_count <= mispredict_count + 32'd1;
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit with ENTRIES=64, TAG_W=8.
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic reset_n, flush_i, update_valid, update_taken, update_predicted;
  logic [31:0] lookup_pc, update_pc, update_target;
  logic predict_taken, ready;
  logic [31:0] predict_target, mispredict_count;
  int vecs = 0;
  int errs = 0;

  branch_predict_unit #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .lookup_pc(lookup_pc),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_predicted(update_predicted),
    .ready(ready), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pred);
    update_valid = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt; update_predicted = pred;
    step();
    update_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
    lookup_pc = pc;
    #1;
    vecs++;
    if (predict_taken !== exp_tk || predict_target !== exp_tgt) begin
      errs++;
      $display("FAIL %s pc=%h got taken=%b target=%h want taken=%b target=%h",
               name, pc, predict_taken, predict_target, exp_tk, exp_tgt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush_i = 1'b0; update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_predicted = 1'b0; lookup_pc = 32'h100;
    repeat (3) step();
    vecs++;
    if (ready !== 1'b0 || mispredict_count !== 32'd0) begin
      errs++; $display("FAIL reset_state got ready=%b cnt=%0d want ready=0 cnt=0", ready, mispredict_count);
    end
    look("reset_lookup", 32'h100, 1'b0, 32'h104);
    reset_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      vecs++;
      if (ready !== (i == 64)) begin
        errs++; $display("FAIL init_ready edge=%0d got %b want %b", i, ready, i == 64);
      end
      if (i < 64) begin
        vecs++;
        if (predict_taken !== 1'b0) begin
          errs++; $display("FAIL init_taken edge=%0d got %b want 0", i, predict_taken);
        end
      end
    end
    look("ready_lookup", 32'h100, 1'b0, 32'h104);
  endtask

  task automatic test_alloc();
    upd(32'h200, 1'b1, 32'h80, 1'b1);
    look("alloc_taken", 32'h200, 1'b1, 32'h80);
    upd(32'h200, 1'b0, 32'h0, 1'b0);
    look("alloc_nt1", 32'h200, 1'b0, 32'h204);
    upd(32'h200, 1'b0, 32'h0, 1'b0);
    look("alloc_nt2", 32'h200, 1'b0, 32'h204);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) upd(32'h200, 1'b1, 32'h300, 1'b1);
    look("sat_4taken", 32'h200, 1'b1, 32'h300);
    upd(32'h200, 1'b0, 32'h0, 1'b0);
    look("sat_11_to_10", 32'h200, 1'b1, 32'h300);
    upd(32'h200, 1'b0, 32'h0, 1'b0);
    look("sat_10_to_01", 32'h200, 1'b0, 32'h204);
  endtask

  task automatic test_no_bypass();
    update_valid = 1'b1; update_pc = 32'h400; update_taken = 1'b1;
    update_target = 32'h44; update_predicted = 1'b1;
    look("bypass_same_cycle", 32'h400, 1'b0, 32'h404);
    step();
    update_valid = 1'b0;
    look("bypass_next_cycle", 32'h400, 1'b1, 32'h44);
  endtask

  task automatic test_alias();
    upd(32'h200, 1'b1, 32'h80, 1'b1);
    upd(32'h300, 1'b1, 32'h90, 1'b1);
    look("alias_old_miss", 32'h200, 1'b0, 32'h204);
    look("alias_new_hit", 32'h300, 1'b1, 32'h90);
  endtask

  task automatic test_mispredict();
    upd(32'h500, 1'b1, 32'h50, 1'b0);
    upd(32'h500, 1'b0, 32'h0, 1'b1);
    upd(32'h500, 1'b1, 32'h50, 1'b1);
    upd(32'h504, 1'b0, 32'h0, 1'b1);
    vecs++;
    if (mispredict_count !== 32'd3) begin
      errs++; $display("FAIL mispredict_count got %0d want 3", mispredict_count);
    end
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    update_valid = 1'b1; update_pc = 32'h600; update_taken = 1'b1;
    update_target = 32'h66; update_predicted = 1'b0;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      vecs++;
      if (ready !== 1'b0) begin
        errs++; $display("FAIL flush_ready cycle=%0d got %b want 0", i, ready);
      end
      step();
    end
    update_valid = 1'b0;
    vecs++;
    if (ready !== 1'b1 || mispredict_count !== 32'd3) begin
      errs++; $display("FAIL flush_end got ready=%b cnt=%0d want ready=1 cnt=3", ready, mispredict_count);
    end
    look("flush_miss_200", 32'h200, 1'b0, 32'h204);
    look("flush_miss_300", 32'h300, 1'b0, 32'h304);
    look("flush_miss_400", 32'h400, 1'b0, 32'h404);
    look("flush_miss_600", 32'h600, 1'b0, 32'h604);
  endtask

  task automatic test_async_reset();
    upd(32'h700, 1'b1, 32'h70, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (10) step();
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if (ready !== 1'b0 || mispredict_count !== 32'd0) begin
      errs++; $display("FAIL async_reset got ready=%b cnt=%0d want ready=0 cnt=0", ready, mispredict_count);
    end
    step();
    reset_n = 1'b1;
    repeat (63) step();
    vecs++;
    if (ready !== 1'b0) begin
      errs++; $display("FAIL async_resweep_63 got %b want 0", ready);
    end
    step();
    vecs++;
    if (ready !== 1'b1) begin
      errs++; $display("FAIL async_resweep_64 got %b want 1", ready);
    end
    look("async_miss_700", 32'h700, 1'b0, 32'h704);
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturate();
    test_no_bypass();
    test_alias();
    test_mispredict();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
